// File: rtl/ps2_rx_fifo_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_rx_fifo_pkg;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} ps2_state_t;

  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned PS2_FRAME_BITS = 11;

  // Odd parity holds when the data byte and the parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// PS/2 line inputs plus the byte FIFO drain handshake.
interface ps2_rx_fifo_if;
  import ps2_rx_fifo_pkg::*;

  logic                     ps2_clk;
  logic                     ps2_data;
  logic [PS2_DATA_BITS-1:0] data;
  logic                     ready;
  logic                     nextdata_n;
  logic                     overflow;
  logic                     frame_err;

  modport master (output ps2_clk, ps2_data, nextdata_n,
                  input  data, ready, overflow, frame_err);
  modport slave  (input  ps2_clk, ps2_data, nextdata_n,
                  output data, ready, overflow, frame_err);
endinterface

// File: rtl/ps2_rx_fifo_edge_sync.sv
// Synchronises the raw PS/2 lines and flags falling edges of ps2_clk.
module ps2_rx_fifo_edge_sync (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_c_o,
  output logic bit_o
);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;

  // Two-flop synchronisers plus one history flop on the clock line; idle level is 1.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign fall_c_o = clk_prev_q & ~clk_sync_q[1];
  assign bit_o    = data_sync_q[1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: deframes 11-bit frames and buffers bytes in a FIFO.
// Optional build macro PS2_PARITY_CHECK_EN: when defined, frames failing odd parity
// are dropped with a frame_err pulse; otherwise the parity bit is consumed and ignored.
module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          clrn,
  ps2_rx_fifo_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BW = $clog2(PS2_FRAME_BITS);

  logic                     fall_c;
  logic                     rx_bit;

  ps2_state_t               state_q;
  logic [PS2_DATA_BITS-1:0] sr_q;
  logic [BW-1:0]            bit_cnt_q;
  logic [TW-1:0]            tmo_q;
  logic                     frame_err_q;
`ifdef PS2_PARITY_CHECK_EN
  logic                     parity_q;
`endif

  logic [PS2_DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]            wptr_q, wptr_d;
  logic [AW-1:0]            rptr_q, rptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [PS2_DATA_BITS-1:0] data_q, data_d;
  logic                     ready_q;
  logic                     overflow_q;

  logic                     parity_ok_c;
  logic                     timeout_c;
  logic                     push_c;
  logic                     pop_c;
  logic                     wr_c;

  ps2_rx_fifo_edge_sync u_sync (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk_i  (bus.ps2_clk),
    .ps2_data_i (bus.ps2_data),
    .fall_c_o   (fall_c),
    .bit_o      (rx_bit)
  );

  // Frame acceptance, timeout detection and FIFO next-state.
  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    parity_ok_c = odd_parity_ok(sr_q, parity_q);
`else
    parity_ok_c = 1'b1;
`endif
    timeout_c = (state_q != S_IDLE) && !fall_c && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    push_c    = fall_c && (state_q == S_STOP) && rx_bit && parity_ok_c;
    pop_c     = ready_q && !bus.nextdata_n;
    wr_c      = push_c && ((count_q != CW'(DEPTH)) || pop_c);
    wptr_d    = wr_c  ? wptr_q + AW'(1) : wptr_q;
    rptr_d    = pop_c ? rptr_q + AW'(1) : rptr_q;
    count_d   = count_q;
    case ({wr_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Head after this cycle's update; a byte written into the new head slot bypasses memory.
    data_d = (wr_c && (wptr_q == rptr_d)) ? sr_q : mem_q[rptr_d];
  end

  // Deframing FSM and inter-edge timeout; advances only on a ps2_clk fall.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      if ((state_q == S_IDLE) || fall_c) tmo_q <= '0;
      else                               tmo_q <= tmo_q + TW'(1);

      if (timeout_c) begin
        state_q     <= S_IDLE;
        frame_err_q <= 1'b1;
      end else if (fall_c) begin
        case (state_q)
          S_IDLE: begin
            if (!rx_bit) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
            end
          end
          S_DATA: begin
            sr_q      <= {rx_bit, sr_q[PS2_DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + BW'(1);
            if (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) state_q <= S_PARITY;
          end
          S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            parity_q <= rx_bit;
`endif
            state_q  <= S_STOP;
          end
          S_STOP: begin
            if (!push_c) frame_err_q <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Byte FIFO with registered head, ready and sticky overflow.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_c) mem_q[wptr_q] <= sr_q;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      data_q  <= data_d;
      ready_q <= (count_d != '0);
      if (push_c && !wr_c) overflow_q <= 1'b1;
    end
  end

  assign bus.data      = data_q;
  assign bus.ready     = ready_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: framing, latency, FIFO order, overflow, parity, timeout.
module tb_ps2_rx_fifo;
  import ps2_rx_fifo_pkg::*;

  localparam int unsigned TMO = 300;

  logic clk;
  logic clrn;
  int   total;
  int   bad;
  int   err_seen;

  ps2_rx_fifo_if bus ();

  ps2_rx_fifo #(.DEPTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_err pulses.
  always @(posedge clk) if (bus.frame_err === 1'b1) err_seen++;

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                           input logic stop);
    logic p;
    p = ~(^b) ^ bad_par;
    return {stop, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.ps2_data = bits[i];
      repeat (3) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (8) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0, 1'b1), 11);
  endtask

  task automatic pop();
    @(negedge clk) bus.nextdata_n = 1'b0;
    @(negedge clk) bus.nextdata_n = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk) clrn = 1'b0;
    @(negedge clk) clrn = 1'b1;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    bus.nextdata_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.data !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h exp=00", bus.data); end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", bus.ready); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", bus.overflow); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%0b exp=0", bus.frame_err); end
    clrn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_latency();
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 10);
    @(negedge clk) bus.ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    bus.ps2_clk = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL lat_ready_early got=%0b exp=0", bus.ready); end
    @(posedge clk); #1;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL lat_ready got=%0b exp=1", bus.ready); end
    total++; if (bus.data !== 8'h1C) begin bad++; $display("FAIL lat_data got=%0h exp=1c", bus.data); end
    repeat (6) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (3) @(negedge clk);
    pop();
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL lat_pop_ready got=%0b exp=0", bus.ready); end
  endtask

  task automatic test_order();
    logic [7:0] exp [3];
    int e0;
    exp = '{8'hE0, 8'hF0, 8'h74};
    e0 = err_seen;
    for (int i = 0; i < 3; i++) send_frame(exp[i]);
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.ready !== 1'b1 || bus.data !== exp[i]) begin
        bad++; $display("FAIL order_%0d got=%0h/%0b exp=%0h/1", i, bus.data, bus.ready, exp[i]);
      end
      pop();
    end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL order_empty got=%0b exp=0", bus.ready); end
    total++; if (err_seen != e0) begin bad++; $display("FAIL order_ferr got=%0d exp=0", err_seen - e0); end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      b = 8'(i);
      send_frame(b);
    end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b exp=1", bus.overflow); end
    for (int i = 1; i <= 8; i++) begin
      b = 8'(i);
      total++; if (bus.ready !== 1'b1 || bus.data !== b) begin
        bad++; $display("FAIL ovf_pop_%0d got=%0h/%0b exp=%0h/1", i, bus.data, bus.ready, b);
      end
      pop();
    end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0b exp=0", bus.ready); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", bus.overflow); end
    send_frame(8'h33);
    total++; if (bus.data !== 8'h33) begin bad++; $display("FAIL ovf_refill got=%0h exp=33", bus.data); end
    send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 4);
    @(negedge clk) clrn = 1'b0;
    #1;
    total++; if (bus.data !== 8'h00 || bus.ready !== 1'b0 || bus.overflow !== 1'b0 || bus.frame_err !== 1'b0) begin
      bad++; $display("FAIL midreset got=%0h/%0b/%0b/%0b exp=00/0/0/0", bus.data, bus.ready, bus.overflow, bus.frame_err);
    end
    total++; if (dut.state_q !== S_IDLE) begin bad++; $display("FAIL midreset_state got=%0d exp=0", dut.state_q); end
    @(negedge clk) clrn = 1'b1;
    send_frame(8'h1C);
    total++; if (bus.ready !== 1'b1 || bus.data !== 8'h1C) begin
      bad++; $display("FAIL midreset_recover got=%0h/%0b exp=1c/1", bus.data, bus.ready);
    end
    pop();
  endtask

  task automatic test_parity();
    int e0;
    apply_reset();
    e0 = err_seen;
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
`ifdef PS2_PARITY_CHECK_EN
    total++; if (err_seen - e0 != 1) begin bad++; $display("FAIL par_ferr got=%0d exp=1", err_seen - e0); end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL par_ready got=%0b exp=0", bus.ready); end
`else
    total++; if (err_seen != e0) begin bad++; $display("FAIL par_ferr got=%0d exp=0", err_seen - e0); end
    total++; if (bus.ready !== 1'b1 || bus.data !== 8'h1C) begin
      bad++; $display("FAIL par_data got=%0h/%0b exp=1c/1", bus.data, bus.ready);
    end
    pop();
`endif
    e0 = err_seen;
    send_bits(mk_frame(8'h42, 1'b0, 1'b0), 11);
    total++; if (err_seen - e0 != 1 || bus.ready !== 1'b0) begin
      bad++; $display("FAIL stop_err got=%0d/%0b exp=1/0", err_seen - e0, bus.ready);
    end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_seen;
    send_bits(mk_frame(8'hA5, 1'b0, 1'b1), 5);
    repeat (TMO + 50) @(negedge clk);
    total++; if (err_seen - e0 != 1) begin bad++; $display("FAIL tmo_ferr got=%0d exp=1", err_seen - e0); end
    total++; if (dut.state_q !== S_IDLE) begin bad++; $display("FAIL tmo_state got=%0d exp=0", dut.state_q); end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL tmo_ready got=%0b exp=0", bus.ready); end
    send_frame(8'hF0);
    total++; if (bus.ready !== 1'b1 || bus.data !== 8'hF0) begin
      bad++; $display("FAIL tmo_next got=%0h/%0b exp=f0/1", bus.data, bus.ready);
    end
    total++; if (err_seen - e0 != 1) begin bad++; $display("FAIL tmo_next_ferr got=%0d exp=1", err_seen - e0); end
    pop();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] b;
    int e0;
    apply_reset();
    e0 = err_seen;
    for (int i = 0; i < 8; i++) begin
      b = 8'hA0 + 8'(i);
      send_frame(b);
    end
    total++; if (bus.overflow !== 1'b0 || bus.data !== 8'hA0) begin
      bad++; $display("FAIL full_pre got=%0h/%0b exp=a0/0", bus.data, bus.overflow);
    end
    send_bits(mk_frame(8'hA8, 1'b0, 1'b1), 10);
    @(negedge clk) bus.ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    bus.ps2_clk = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk) bus.nextdata_n = 1'b0;
    @(negedge clk) bus.nextdata_n = 1'b1;
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL full_ovf got=%0b exp=0", bus.overflow); end
    repeat (5) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      b = 8'hA0 + 8'(i);
      total++; if (bus.ready !== 1'b1 || bus.data !== b) begin
        bad++; $display("FAIL full_pop_%0d got=%0h/%0b exp=%0h/1", i, bus.data, bus.ready, b);
      end
      pop();
    end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL full_empty got=%0b exp=0", bus.ready); end
    total++; if (err_seen != e0) begin bad++; $display("FAIL full_ferr got=%0d exp=0", err_seen - e0); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    err_seen = 0;
    test_reset();
    test_single_latency();
    test_order();
    test_overflow();
    test_parity();
    test_timeout();
    test_full_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
